time_set_ctrl: RTL and testbench

Key-driven mode controller for the 6-digit HH.MM.SS timekeeper. Debounces the four raw push-buttons and runs a RUN/PAUSE/SET state machine. Drives the timekeeper's run enable, clear and parallel-load controls. In set mode it supplies the values to display and a per-digit blink mask to the digit-scan block.

---
 rtl/time_set_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - key-driven RUN/PAUSE/SET mode controller for the HH.MM.SS timekeeper
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   keys[3:0]          raw active-low buttons: [0] clear, [1] run/pause/abort, [2] mode/next, [3] increment
//   cur_hours/minutes/seconds   live time from the timekeeper
//   run_en             timekeeper count enable
//   clear_time         one-cycle pulse: timekeeper zeroes time
//   load_en            one-cycle pulse: timekeeper loads load_*
//   load_hours/minutes/seconds  shadow (edit) registers
//   disp_hours/minutes/seconds  value for the digit-scan block
//   blink_mask[5:0]    1 = blank digit (bit0/1 sec, bit2/3 min, bit4/5 hours)
//   mode[2:0]          0 RUN, 1 PAUSE, 2 SET_HH, 3 SET_MM, 4 SET_SS
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 12500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keys,
    input  logic [5:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    output logic       run_en,
    output logic       clear_time,
    output logic       load_en,
    output logic [5:0] load_hours,
    output logic [5:0] load_minutes,
    output logic [5:0] load_seconds,
    output logic [5:0] disp_hours,
    output logic [5:0] disp_minutes,
    output logic [5:0] disp_seconds,
    output logic [5:0] blink_mask,
    output logic [2:0] mode
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLW  = $clog2(BLINK_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_CYCLES - 1);
    localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_PAUSE  = 3'd1,
        ST_SET_HH = 3'd2,
        ST_SET_MM = 3'd3,
        ST_SET_SS = 3'd4
    } state_t;

    // ---------------- key synchroniser and debouncers ----------------
    logic [3:0]     sync_q1, sync_q2;
    logic [3:0]     db_level;
    logic [3:0]     press;
    logic [DBW-1:0] db_cnt [4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1  <= '1;
            sync_q2  <= '1;
            db_level <= '1;
            press    <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_q1 <= keys;
            sync_q2 <= sync_q1;
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync_q2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= sync_q2[i];
                    // old level 1 means this is a 1->0 (press) transition
                    press[i]    <= db_level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ---------------- key3 auto-repeat ----------------
    logic [RW-1:0] rpt_cnt;
    logic          rpt_armed;
    logic          rpt_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            rpt_fire  <= 1'b0;
        end else begin
            rpt_fire <= 1'b0;
            if (db_level[3]) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b0;
            end else if (!rpt_armed) begin
                if (rpt_cnt == RD_LAST) begin
                    rpt_fire  <= 1'b1;
                    rpt_cnt   <= '0;
                    rpt_armed <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end else if (rpt_cnt == RP_LAST) begin
                rpt_fire <= 1'b1;
                rpt_cnt  <= '0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

    // ---------------- event priority: key0 > key2 > key1 > key3 ----------------
    logic ev_clr, ev_next, ev_run, ev_inc;

    always_comb begin
        ev_clr  = press[0];
        ev_next = press[2] & ~press[0];
        ev_run  = press[1] & ~press[0] & ~press[2];
        ev_inc  = (press[3] | rpt_fire) & ~(|press[2:0]);
    end

    // ---------------- FSM ----------------
    state_t         state, nxt_state;
    logic           ret_run;
    logic [5:0]     sh_hours, sh_minutes, sh_seconds;
    logic [BLW-1:0] blink_cnt, blink_cnt_nxt;
    logic           blink_phase, blink_phase_nxt;
    logic           nxt_in_set;

    function automatic logic [5:0] edit_mask(input state_t s, input logic ph);
        logic [5:0] m;
        m = 6'b000000;
        if (ph) begin
            case (s)
                ST_SET_HH: m = 6'b110000;
                ST_SET_MM: m = 6'b001100;
                ST_SET_SS: m = 6'b000011;
                default:   m = 6'b000000;
            endcase
        end
        return m;
    endfunction

    always_comb begin
        nxt_state = state;
        case (state)
            ST_RUN: begin
                if (ev_next)     nxt_state = ST_SET_HH;
                else if (ev_run) nxt_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (ev_clr || ev_run) nxt_state = ST_RUN;
                else if (ev_next)     nxt_state = ST_SET_HH;
            end
            ST_SET_HH: begin
                if (ev_next)     nxt_state = ST_SET_MM;
                else if (ev_run) nxt_state = ret_run ? ST_RUN : ST_PAUSE;
            end
            ST_SET_MM: begin
                if (ev_next)     nxt_state = ST_SET_SS;
                else if (ev_run) nxt_state = ret_run ? ST_RUN : ST_PAUSE;
            end
            ST_SET_SS: begin
                if (ev_next || ev_run) nxt_state = ret_run ? ST_RUN : ST_PAUSE;
            end
            default: nxt_state = ST_PAUSE;
        endcase

        nxt_in_set = (nxt_state == ST_SET_HH) || (nxt_state == ST_SET_MM) ||
                     (nxt_state == ST_SET_SS);

        // Entering a SET state or incrementing restarts the blink visible,
        // so the field being adjusted never disappears under the user.
        if (!nxt_in_set || (nxt_state != state) || ev_inc) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = 1'b0;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = ~blink_phase;
        end else begin
            blink_cnt_nxt   = blink_cnt + 1'b1;
            blink_phase_nxt = blink_phase;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_PAUSE;
            run_en      <= 1'b0;
            clear_time  <= 1'b0;
            load_en     <= 1'b0;
            ret_run     <= 1'b0;
            sh_hours    <= '0;
            sh_minutes  <= '0;
            sh_seconds  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            blink_mask  <= '0;
        end else begin
            state       <= nxt_state;
            run_en      <= (nxt_state == ST_RUN);
            clear_time  <= ev_clr && ((state == ST_RUN) || (state == ST_PAUSE));
            load_en     <= ev_next && (state == ST_SET_SS);
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            blink_mask  <= edit_mask(nxt_state, blink_phase_nxt);

            case (state)
                ST_RUN, ST_PAUSE: begin
                    if (ev_next) begin
                        sh_hours   <= cur_hours;
                        sh_minutes <= cur_minutes;
                        sh_seconds <= cur_seconds;
                        ret_run    <= (state == ST_RUN);
                    end
                end
                default: begin
                    if (ev_clr) begin
                        sh_hours   <= '0;
                        sh_minutes <= '0;
                        sh_seconds <= '0;
                    end else if (ev_inc) begin
                        case (state)
                            ST_SET_HH: sh_hours   <= (sh_hours   == 6'd23) ? 6'd0 : sh_hours   + 6'd1;
                            ST_SET_MM: sh_minutes <= (sh_minutes == 6'd59) ? 6'd0 : sh_minutes + 6'd1;
                            ST_SET_SS: sh_seconds <= (sh_seconds == 6'd59) ? 6'd0 : sh_seconds + 6'd1;
                            default:   ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign load_hours   = sh_hours;
    assign load_minutes = sh_minutes;
    assign load_seconds = sh_seconds;
    assign mode         = state;

    always_comb begin
        if ((state == ST_RUN) || (state == ST_PAUSE)) begin
            disp_hours   = cur_hours;
            disp_minutes = cur_minutes;
            disp_seconds = cur_seconds;
        end else begin
            disp_hours   = sh_hours;
            disp_minutes = sh_minutes;
            disp_seconds = sh_seconds;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keys;
    logic [5:0] cur_hours, cur_minutes, cur_seconds;
    logic       run_en, clear_time, load_en;
    logic [5:0] load_hours, load_minutes, load_seconds;
    logic [5:0] disp_hours, disp_minutes, disp_seconds;
    logic [5:0] blink_mask;
    logic [2:0] mode;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES(8),
        .REPEAT_DELAY(16),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk), .rst(rst), .keys(keys),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .run_en(run_en), .clear_time(clear_time), .load_en(load_en),
        .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
        .disp_hours(disp_hours), .disp_minutes(disp_minutes), .disp_seconds(disp_seconds),
        .blink_mask(blink_mask), .mode(mode)
    );

    typedef struct {
        logic [3:0] low;
        int         hold;
        logic       set_cur;
        logic [5:0] ch, cm, cs;
        int         e_mode;
        int         e_run;
        int         eh, em, es;
        logic       e_load;
        logic       e_clr;
    } vec_t;

    typedef struct {
        string name;
        int    e_mode, e_run, eh, em, es;
    } exp_t;

    vec_t        vt[$];
    exp_t        exp_q[$];
    logic [17:0] load_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_load = 0;
    int          n_clr = 0;
    int          exp_clr = 0;
    int          split1, split2;
    int          prev_h, prev_m, prev_s;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input logic [3:0] low, input int hold, input logic set_cur,
                       input int ch, input int cm, input int cs,
                       input int e_mode, input int e_run, input int eh, input int em, input int es,
                       input logic e_load, input logic e_clr);
        vec_t v;
        v.low = low; v.hold = hold; v.set_cur = set_cur;
        v.ch = 6'(ch); v.cm = 6'(cm); v.cs = 6'(cs);
        v.e_mode = e_mode; v.e_run = e_run; v.eh = eh; v.em = em; v.es = es;
        v.e_load = e_load; v.e_clr = e_clr;
        vt.push_back(v);
    endtask

    task automatic press(input logic [3:0] low, input int hold);
        @(posedge clk); #1 keys = ~low;
        repeat (hold) @(posedge clk);
        #1 keys = 4'hF;
        repeat (12) @(posedge clk);
    endtask

    task automatic push_exp(input string name, input int m, input int r, input int h, input int mi, input int s);
        exp_t e;
        e.name = name; e.e_mode = m; e.e_run = r; e.eh = h; e.em = mi; e.es = s;
        exp_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.name, "_mode"}, int'(mode), e.e_mode);
        chk({e.name, "_run_en"}, int'(run_en), e.e_run);
        chk({e.name, "_disp_h"}, int'(disp_hours), e.eh);
        chk({e.name, "_disp_m"}, int'(disp_minutes), e.em);
        chk({e.name, "_disp_s"}, int'(disp_seconds), e.es);
        if (e.e_mode < 2) chk({e.name, "_mask"}, int'(blink_mask), 0);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vt[i].set_cur) begin
                cur_hours = vt[i].ch; cur_minutes = vt[i].cm; cur_seconds = vt[i].cs;
            end
            if (vt[i].e_load) load_q.push_back({6'(prev_h), 6'(prev_m), 6'(prev_s)});
            if (vt[i].e_clr) exp_clr++;
            push_exp($sformatf("vec%0d", i), vt[i].e_mode, vt[i].e_run, vt[i].eh, vt[i].em, vt[i].es);
            press(vt[i].low, vt[i].hold);
            compare_front();
            prev_h = vt[i].eh; prev_m = vt[i].em; prev_s = vt[i].es;
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (load_en) begin
                n_load++;
                if (load_q.size() == 0) begin
                    chk("load_unexpected", 1, 0);
                end else begin
                    logic [17:0] e;
                    e = load_q.pop_front();
                    chk("load_hours", int'(load_hours), int'(e[17:12]));
                    chk("load_minutes", int'(load_minutes), int'(e[11:6]));
                    chk("load_seconds", int'(load_seconds), int'(e[5:0]));
                end
            end
            if (clear_time) n_clr++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic found;
        rst = 1'b0; keys = 4'hF;
        cur_hours = 6'd12; cur_minutes = 6'd34; cur_seconds = 6'd56;

        // RUN/PAUSE path, then SET_HH increments with wrap
        add(4'b0010, 3, 0, 0, 0, 0, 1, 0, 12, 34, 56, 0, 0);
        add(4'b0010, 8, 0, 0, 0, 0, 0, 1, 12, 34, 56, 0, 0);
        split1 = vt.size();
        for (int k = 1; k <= 12; k++)
            add(4'b1000, 6, 0, 0, 0, 0, 2, 0, (12 + k) % 24, 34, 56, 0, 0);
        add(4'b0100, 6, 0, 0, 0, 0, 3, 0, 0, 34, 56, 0, 0);
        add(4'b1000, 6, 0, 0, 0, 0, 3, 0, 0, 35, 56, 0, 0);
        add(4'b1000, 6, 0, 0, 0, 0, 3, 0, 0, 36, 56, 0, 0);
        add(4'b0100, 6, 0, 0, 0, 0, 4, 0, 0, 36, 56, 0, 0);
        add(4'b1000, 6, 0, 0, 0, 0, 4, 0, 0, 36, 57, 0, 0);
        add(4'b1000, 6, 0, 0, 0, 0, 4, 0, 0, 36, 58, 0, 0);
        add(4'b1000, 6, 0, 0, 0, 0, 4, 0, 0, 36, 59, 0, 0);
        add(4'b1000, 6, 0, 0, 0, 0, 4, 0, 0, 36, 0, 0, 0);
        add(4'b1000, 6, 0, 0, 0, 0, 4, 0, 0, 36, 1, 0, 0);
        add(4'b0100, 6, 0, 0, 0, 0, 0, 1, 12, 34, 56, 1, 0);
        // abort from SET_MM entered out of PAUSE
        add(4'b0010, 6, 0, 0, 0, 0, 1, 0, 12, 34, 56, 0, 0);
        add(4'b0100, 6, 0, 0, 0, 0, 2, 0, 12, 34, 56, 0, 0);
        add(4'b0100, 6, 0, 0, 0, 0, 3, 0, 12, 34, 56, 0, 0);
        add(4'b0010, 6, 1, 5, 6, 58, 1, 0, 5, 6, 58, 0, 0);
        add(4'b0100, 6, 0, 0, 0, 0, 2, 0, 5, 6, 58, 0, 0);
        add(4'b0100, 6, 0, 0, 0, 0, 3, 0, 5, 6, 58, 0, 0);
        add(4'b0100, 6, 0, 0, 0, 0, 4, 0, 5, 6, 58, 0, 0);
        split2 = vt.size();
        // zero in SET, abort, clear priority in RUN, enter SET_HH
        add(4'b0001, 6, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0);
        add(4'b0010, 6, 0, 0, 0, 0, 1, 0, 5, 6, 58, 0, 0);
        add(4'b0010, 6, 0, 0, 0, 0, 0, 1, 5, 6, 58, 0, 0);
        add(4'b0011, 6, 0, 0, 0, 0, 0, 1, 5, 6, 58, 0, 1);
        add(4'b0100, 6, 0, 0, 0, 0, 2, 0, 5, 6, 58, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mode", int'(mode), 1);
        chk("reset_run_en", int'(run_en), 0);
        chk("reset_mask", int'(blink_mask), 0);
        chk("reset_load", int'({load_hours, load_minutes, load_seconds}), 0);
        chk("reset_pulses", int'({clear_time, load_en}), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);

        run_range(0, split1);

        // blink: visible 8 cycles, blanked 8, visible again
        @(posedge clk); #1 keys = 4'b1011;
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (mode == 3'd2) begin found = 1'b1; break; end
        end
        chk("enter_set_hh", int'(found), 1);
        keys = 4'hF;
        chk("set_hh_disp", int'({disp_hours, disp_minutes, disp_seconds}), int'({6'd12, 6'd34, 6'd56}));
        for (int k = 0; k < 24; k++) begin
            if (k == 0 || k == 7 || k == 8 || k == 15 || k == 16 || k == 23)
                chk($sformatf("blink_k%0d", k), int'(blink_mask), ((k / 8) % 2 == 1) ? 6'b110000 : 0);
            @(negedge clk);
        end
        repeat (8) @(posedge clk);

        run_range(split1, split2);

        // key3 held: one press plus three repeats, 58 -> 2
        push_exp("repeat", 4, 0, 5, 6, 2);
        press(4'b1000, 26);
        compare_front();

        run_range(split2, vt.size());

        // async reset in SET_HH discards the shadow
        @(posedge clk); #2 rst = 1'b0; #1;
        chk("rst_mid_mode", int'(mode), 1);
        chk("rst_mid_mask", int'(blink_mask), 0);
        chk("rst_mid_run_en", int'(run_en), 0);
        chk("rst_mid_shadow", int'({load_hours, load_minutes, load_seconds}), 0);
        chk("rst_mid_load_en", int'(load_en), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        push_exp("after_rst", 1, 0, 5, 6, 58);
        compare_front();

        chk("load_pulse_count", n_load, 1);
        chk("load_queue_left", load_q.size(), 0);
        chk("clear_pulse_count", n_clr, exp_clr);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
